// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types and constants for the polar-to-cartesian CORDIC
// FSM states, inverse-gain pre-scale constant and the arctangent micro-rotation table.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 1/CORDIC-gain in Q16, applied to the magnitude before rotation
    localparam logic [15:0] K_Q16 = 16'h9B75;

    // round(atan(2^-i) * 2^16 / (2*pi)); other angle widths rescale from this base
    function automatic int atan_lut(input int i, input int aw);
        int base;
        case (i)
            0:       base = 8192;
            1:       base = 4836;
            2:       base = 2555;
            3:       base = 1297;
            4:       base = 651;
            5:       base = 326;
            6:       base = 163;
            7:       base = 81;
            8:       base = 41;
            9:       base = 20;
            10:      base = 10;
            11:      base = 5;
            12:      base = 3;
            13:      base = 1;
            14:      base = 1;
            default: base = 0;
        endcase
        if (aw >= 16) begin
            return base << (aw - 16);
        end else begin
            return (base + (1 << (15 - aw))) >> (16 - aw);
        end
    endfunction

endpackage

// File: rtl/polar_quadrant_map.sv
// rtl/polar_quadrant_map.sv - coarse quadrant pre-rotation of the scaled magnitude
// Places m on the axis selected by q, with two guard LSBs appended for the rotation datapath.
module polar_quadrant_map #(
    parameter int DATA_W = 16,
    parameter int XY_W   = DATA_W + 3
) (
    input  logic [DATA_W-1:0] i_mag,
    input  logic [1:0]        i_quad,
    output logic [XY_W-1:0]   o_x0,
    output logic [XY_W-1:0]   o_y0
);

    logic signed [XY_W-1:0] w_pos;
    logic signed [XY_W-1:0] w_neg;

    assign w_pos = XY_W'({1'b0, i_mag, 2'b00});
    assign w_neg = -w_pos;

    always_comb begin
        o_x0 = '0;
        o_y0 = '0;
        case (i_quad)
            2'd0:    o_x0 = w_pos;
            2'd1:    o_y0 = w_pos;
            2'd2:    o_x0 = w_neg;
            default: o_y0 = w_neg;
        endcase
    end

endmodule

// File: rtl/polar_to_cartesian.sv
// rtl/polar_to_cartesian.sv - iterative rotation-mode CORDIC: (mag, angle) -> signed (x, y)
// One micro-rotation per clock; operands captured at accept, result held until taken.
module polar_to_cartesian
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16,
    parameter int ITER    = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [DATA_W-1:0]  mag_i,
    input  logic [ANGLE_W-1:0] angle_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [DATA_W:0]    x_o,
    output logic [DATA_W:0]    y_o
);

    localparam int XY_W  = DATA_W + 3;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    state_t r_state;
    state_t w_next;

    logic signed [XY_W-1:0]    r_x;
    logic signed [XY_W-1:0]    r_y;
    logic signed [ANGLE_W-1:0] r_z;
    logic [CNT_W-1:0]          r_iter;
    logic [DATA_W:0]           r_x_out;
    logic [DATA_W:0]           r_y_out;
    logic                      r_valid;

    logic [DATA_W+15:0]        w_prod;
    logic [DATA_W-1:0]         w_m;
    logic [XY_W-1:0]           w_x0;
    logic [XY_W-1:0]           w_y0;
    logic                      w_d;
    logic                      w_last;
    logic signed [XY_W-1:0]    w_xs;
    logic signed [XY_W-1:0]    w_ys;
    logic signed [XY_W-1:0]    w_x_nx;
    logic signed [XY_W-1:0]    w_y_nx;
    logic signed [ANGLE_W-1:0] w_atan;
    logic signed [ANGLE_W-1:0] w_z_nx;
    logic signed [XY_W-1:0]    w_x_rnd;
    logic signed [XY_W-1:0]    w_y_rnd;

    // Pre-scale by 1/gain so the rotated vector lands on the true magnitude
    assign w_prod = (DATA_W + 16)'(mag_i) * (DATA_W + 16)'(K_Q16);
    assign w_m    = DATA_W'(w_prod >> 16);

    polar_quadrant_map #(
        .DATA_W (DATA_W),
        .XY_W   (XY_W)
    ) u_quadrant_map (
        .i_mag  (w_m),
        .i_quad (angle_i[ANGLE_W-1 -: 2]),
        .o_x0   (w_x0),
        .o_y0   (w_y0)
    );

    assign w_d     = ~r_z[ANGLE_W-1];
    assign w_last  = (r_iter == CNT_W'(ITER - 1));
    assign w_xs    = r_x >>> r_iter;
    assign w_ys    = r_y >>> r_iter;
    assign w_atan  = ANGLE_W'(atan_lut(int'(r_iter), ANGLE_W));
    assign w_x_nx  = w_d ? (r_x - w_ys) : (r_x + w_ys);
    assign w_y_nx  = w_d ? (r_y + w_xs) : (r_y - w_xs);
    assign w_z_nx  = w_d ? (r_z - w_atan) : (r_z + w_atan);
    assign w_x_rnd = w_x_nx + XY_W'(2);
    assign w_y_rnd = w_y_nx + XY_W'(2);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_next = ROT;
            ROT:     if (w_last)  w_next = DONE;
            DONE:    if (ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_x    <= w_x0;
                        r_y    <= w_y0;
                        r_z    <= {2'b00, angle_i[ANGLE_W-3:0]};
                        r_iter <= '0;
                    end
                end
                ROT: begin
                    r_x    <= w_x_nx;
                    r_y    <= w_y_nx;
                    r_z    <= w_z_nx;
                    r_iter <= r_iter + CNT_W'(1);
                    // Final micro-rotation feeds the output registers directly
                    if (w_last) begin
                        r_iter  <= '0;
                        r_x_out <= w_x_rnd[DATA_W+2:2];
                        r_y_out <= w_y_rnd[DATA_W+2:2];
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) r_valid <= 1'b0;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = r_valid;
    assign x_o     = r_x_out;
    assign y_o     = r_y_out;

endmodule

// File: tb/tb_polar_to_cartesian.sv
// tb/tb_polar_to_cartesian.sv - self-checking bench for polar_to_cartesian
module tb_polar_to_cartesian;

    localparam int  DATA_W  = 16;
    localparam int  ANGLE_W = 16;
    localparam int  ITER    = 16;
    localparam real PI      = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] mag_i = '0;
    logic [15:0] angle_i = '0;
    logic [16:0] x_o;
    logic [16:0] y_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    polar_to_cartesian #(
        .DATA_W  (DATA_W),
        .ANGLE_W (ANGLE_W),
        .ITER    (ITER)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mag_i   (mag_i),
        .angle_i (angle_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .x_o     (x_o),
        .y_o     (y_o)
    );

    typedef struct {
        int mag;
        int angle;
        int x_lo;
        int x_hi;
        int y_lo;
        int y_hi;
    } vec_t;

    function automatic int sx(input logic [16:0] v);
        return int'($signed(v));
    endfunction

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, want [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    task automatic check_near(input string name, input int act, input real exp_v, input real tol);
        real diff;
        diff = real'(act) - exp_v;
        if (diff < 0.0) diff = -diff;
        n_checks++;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0.2f +/- %0.1f", name, act, exp_v, tol);
        end
    endtask

    // Accept one operand pair, wait for the result, hold it bp cycles, then take it
    task automatic run_txn(input int mag, input int ang, input int bp,
                           output int x, output int y, output int lat,
                           output logic vo_after, output logic ro_after);
        int w;
        @(negedge clk);
        ready_i = 1'b0;
        mag_i   = 16'(mag);
        angle_i = 16'(ang);
        valid_i = 1'b1;
        w = 0;
        while (!ready_o && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        mag_i   = 16'($urandom);
        angle_i = 16'($urandom);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        x = sx(x_o);
        y = sx(y_o);
        repeat (bp) @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i  = 1'b0;
        vo_after = valid_o;
        ro_after = ready_o;
    endtask

    vec_t vecs[8];

    initial begin
        int   x, y, lat, x_hold, y_hold, cnt, mag, ang;
        logic vo, ro, seen;
        real  tol, th;

        vecs[0] = '{1000,  16'h0000,  998,  1002,    -2,     2};
        vecs[1] = '{1000,  16'h2000,  705,   709,   705,   709};
        vecs[2] = '{1000,  16'h4000,   -2,     2,   998,  1002};
        // Table rounding leaves a fraction of an angle LSB; at full scale that is a few output LSB
        vecs[3] = '{65535, 16'hC000,   -8,     8, -65537, -65533};
        vecs[4] = '{0,     16'h1234,    0,     0,     0,     0};
        vecs[5] = '{1000,  16'h8000, -1002, -998,    -2,     2};
        vecs[6] = '{1000,  16'hFFFF,  998,  1002,    -2,     2};
        vecs[7] = '{65535, 16'h0000, 65531, 65535,   -8,     8};

        #2;
        check_rng("reset_valid_o", int'(valid_o), 0, 0);
        check_rng("reset_ready_o", int'(ready_o), 1, 1);
        check_rng("reset_x_o", sx(x_o), 0, 0);
        check_rng("reset_y_o", sx(y_o), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].mag, vecs[i].angle, i % 3, x, y, lat, vo, ro);
            check_rng($sformatf("vec%0d_latency", i), lat, ITER + 1, ITER + 1);
            check_rng($sformatf("vec%0d_x", i), x, vecs[i].x_lo, vecs[i].x_hi);
            check_rng($sformatf("vec%0d_y", i), y, vecs[i].y_lo, vecs[i].y_hi);
            check_rng($sformatf("vec%0d_valid_drop", i), int'(vo), 0, 0);
            check_rng($sformatf("vec%0d_ready_rise", i), int'(ro), 1, 1);
        end

        // Random operands against the trigonometric reference
        for (int i = 0; i < 30; i++) begin
            mag = int'($urandom_range(0, 65535));
            ang = int'($urandom_range(0, 65535));
            run_txn(mag, ang, int'($urandom_range(0, 3)), x, y, lat, vo, ro);
            th  = 2.0 * PI * real'(ang) / 65536.0;
            tol = 3.0 + real'(mag / 2048);
            check_rng($sformatf("rnd%0d_latency", i), lat, ITER + 1, ITER + 1);
            check_near($sformatf("rnd%0d_x mag=%0d ang=%0d", i, mag, ang), x, real'(mag) * $cos(th), tol);
            check_near($sformatf("rnd%0d_y mag=%0d ang=%0d", i, mag, ang), y, real'(mag) * $sin(th), tol);
            check_rng($sformatf("rnd%0d_valid_drop", i), int'(vo), 0, 0);
        end

        // Back-to-back: valid_i held high, operands changed right after the first accept
        @(negedge clk);
        mag_i   = 16'd1000;
        angle_i = 16'h2000;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        mag_i   = 16'd500;
        angle_i = 16'h4000;
        cnt = 0;
        while (!valid_o && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_rng("b2b_first_x", sx(x_o), 705, 709);
        check_rng("b2b_first_y", sx(y_o), 705, 709);
        @(posedge clk);
        #1;
        check_rng("b2b_valid_fall", int'(valid_o), 0, 0);
        check_rng("b2b_ready_rise", int'(ready_o), 1, 1);
        @(posedge clk);
        #1;
        check_rng("b2b_second_accept", int'(ready_o), 0, 0);
        valid_i = 1'b0;
        cnt = 2;
        while (!valid_o && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_rng("b2b_period", cnt, ITER + 2, ITER + 2);
        check_rng("b2b_second_x", sx(x_o), -2, 2);
        check_rng("b2b_second_y", sx(y_o), 498, 502);
        @(posedge clk);
        #1;
        ready_i = 1'b0;

        // Backpressure: result held 10 cycles while the input side is toggled
        @(negedge clk);
        mag_i   = 16'd1000;
        angle_i = 16'h0000;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        cnt = 0;
        while (!valid_o && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        x_hold = sx(x_o);
        y_hold = sx(y_o);
        check_rng("bp_x", x_hold, 998, 1002);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid_i = ~valid_i;
            mag_i   = 16'($urandom);
            angle_i = 16'($urandom);
            @(posedge clk);
            #1;
            check_rng($sformatf("bp%0d_valid", c), int'(valid_o), 1, 1);
            check_rng($sformatf("bp%0d_ready", c), int'(ready_o), 0, 0);
            check_rng($sformatf("bp%0d_x", c), sx(x_o), x_hold, x_hold);
            check_rng($sformatf("bp%0d_y", c), sx(y_o), y_hold, y_hold);
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check_rng("bp_release_valid", int'(valid_o), 0, 0);

        // Reset in the middle of the rotation
        @(negedge clk);
        mag_i   = 16'd2000;
        angle_i = 16'h4000;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_rng("rst_valid_o", int'(valid_o), 0, 0);
        check_rng("rst_x_o", sx(x_o), 0, 0);
        check_rng("rst_y_o", sx(y_o), 0, 0);
        check_rng("rst_ready_o", int'(ready_o), 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (ITER + 3) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check_rng("rst_no_partial", int'(seen), 0, 0);
        check_rng("rst_ready_after", int'(ready_o), 1, 1);
        run_txn(1000, 16'h4000, 0, x, y, lat, vo, ro);
        check_rng("post_rst_latency", lat, ITER + 1, ITER + 1);
        check_rng("post_rst_x", x, -2, 2);
        check_rng("post_rst_y", y, 998, 1002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
